// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned OFFSET_W = 4;

  localparam logic ROW_WRITE = 1'b1;
  localparam logic ROW_READ  = 1'b0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory bus bundle for mem_port_arbiter; slave = arbiter side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [1:0]         req;
  logic [1:0]         req_row;
  logic [ADDR_W-1:0]  req0_addr;
  logic [ADDR_W-1:0]  req1_addr;
  logic [BLOCK_W-1:0] req0_wdata;
  logic [BLOCK_W-1:0] req1_wdata;
  logic [1:0]         done;
  logic [BLOCK_W-1:0] rdata;
  logic               busy;
  logic               gnt_id;
  logic               err;
  logic               mem_req;
  logic               mem_row;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ack;

  modport slave (
    input  req, req_row, req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata, mem_ack,
    output done, rdata, busy, gnt_id, err, mem_req, mem_row, mem_addr, mem_wdata
  );

  modport master (
    output req, req_row, req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata, mem_ack,
    input  done, rdata, busy, gnt_id, err, mem_req, mem_row, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);

  logic r_ptr;
  logic w_idx;

  always_comb begin
    w_idx = 1'b0;
    unique case (i_req)
      2'b01:   w_idx = 1'b0;
      2'b10:   w_idx = 1'b1;
      2'b11:   w_idx = r_ptr;
      default: w_idx = 1'b0;
    endcase
  end

  assign o_gnt     = (i_req == 2'b00) ? 2'b00 : (w_idx ? 2'b10 : 2'b01);
  assign o_gnt_idx = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_en && (i_req != 2'b00)) begin
      r_ptr <= ~w_idx;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory block port between two cache requesters (IDLE -> ISSUE -> RESP).
// Define MEM_TIMEOUT_EN to abort ISSUE after TIMEOUT cycles without mem_ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 15
)
`endif
(
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  logic [1:0]         r_state;
  logic               r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic [BLOCK_W-1:0] r_wdata;
  logic [BLOCK_W-1:0] r_rdata;
  logic               r_gnt_id;
  logic [1:0]         w_gnt;
  logic               w_gnt_idx;
  logic               w_grant;
  logic               w_timeout;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req),
    .i_en      (r_state == S_IDLE),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_grant = (r_state == S_IDLE) && (bus.req != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_err;

  // Abort on the ISSUE cycle that would bring the count to TIMEOUT; a late ack still wins.
  assign w_timeout = (r_state == S_ISSUE) && !bus.mem_ack &&
                     ((r_cnt + 1'b1) == CntW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cnt <= '0;
      end else if ((r_state == S_ISSUE) && !bus.mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_row    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_gnt_id <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state  <= S_ISSUE;
            r_gnt_id <= w_gnt_idx;
            r_row    <= w_gnt[1] ? bus.req_row[1] : bus.req_row[0];
            r_addr   <= block_align(w_gnt[1] ? bus.req1_addr : bus.req0_addr);
            r_wdata  <= w_gnt[1] ? bus.req1_wdata : bus.req0_wdata;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ack) begin
            if (r_row == ROW_READ) begin
              r_rdata <= bus.mem_rdata;
            end
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state so an asynchronous reset drops them at once.
  assign bus.mem_req   = (r_state == S_ISSUE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_RESP) ? (r_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_row   = r_row;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Requester-side view the bench drives, plus the model's pointer and returned data.
  logic [1:0]         pend;
  logic [ADDR_W-1:0]  f_addr  [2];
  logic [BLOCK_W-1:0] f_wdata [2];
  logic               f_row   [2];
  logic               m_ptr;
  logic [BLOCK_W-1:0] m_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_fields(input int i);
    f_addr[i]  = 10'($urandom_range(0, 1023));
    f_wdata[i] = rnd128();
    f_row[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_inputs();
    bus.req        = pend;
    bus.req_row    = {f_row[1], f_row[0]};
    bus.req0_addr  = f_addr[0];
    bus.req1_addr  = f_addr[1];
    bus.req0_wdata = f_wdata[0];
    bus.req1_wdata = f_wdata[1];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst         = 1'b1;
    pend        = 2'b00;
    bus.mem_ack = 1'b0;
    drive_inputs();
    @(negedge clk);
    rst     = 1'b0;
    m_ptr   = 1'b0;
    m_rdata = '0;
  endtask

  // One whole transaction; called at a negedge with pend already holding the requests.
  task automatic serve(input int ack_dly, input bit scramble, input bit reraise,
                       input logic [127:0] rd);
    logic              w;
    logic [ADDR_W-1:0] ea;
    logic              er;
    logic [127:0]      ew;
    int                waited;
    w       = (pend == 2'b11) ? m_ptr : pend[1];
    m_ptr   = ~w;
    ea      = f_addr[w] - (f_addr[w] % 10'd16);
    er      = f_row[w];
    ew      = f_wdata[w];
    drive_inputs();
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("done_single_cycle", 128'(bus.done), 128'(0));
    waited = 0;
    while (bus.mem_req !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    chk("mem_req_rise", 128'(bus.mem_req), 128'(1));
    chk("gnt_id", 128'(bus.gnt_id), 128'(w));
    chk("busy", 128'(bus.busy), 128'(1));
    chk("mem_addr", 128'(bus.mem_addr), 128'(ea));
    chk("mem_row", 128'(bus.mem_row), 128'(er));
    chk("mem_wdata", bus.mem_wdata, ew);
    if (scramble) begin
      f_addr[w]  = 10'h3FF;
      f_wdata[w] = ~f_wdata[w];
      f_row[w]   = ~f_row[w];
      drive_inputs();
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk("hold_mem_req", 128'(bus.mem_req), 128'(1));
      chk("hold_mem_addr", 128'(bus.mem_addr), 128'(ea));
      if (scramble) begin
        chk("hold_mem_row", 128'(bus.mem_row), 128'(er));
        chk("hold_mem_wdata", bus.mem_wdata, ew);
      end
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    if (er == ROW_READ) m_rdata = rd;
    chk("done_pulse", 128'(bus.done), 128'(w ? 2'b10 : 2'b01));
    chk("rdata", bus.rdata, m_rdata);
    chk("mem_req_low_resp", 128'(bus.mem_req), 128'(0));
    chk("err_clear", 128'(bus.err), 128'(0));
    // Stray ack seen in RESP must not touch rdata.
    bus.mem_rdata = rnd128();
    pend[w] = reraise;
    if (reraise) new_fields(int'(w));
    drive_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst           = 1'b0;
    pend          = 2'b00;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 2; i++) new_fields(i);
    drive_inputs();
    m_ptr   = 1'b0;
    m_rdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_rdata", bus.rdata, 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_gnt_id", 128'(bus.gnt_id), 128'(0));
    chk("rst_err", 128'(bus.err), 128'(0));
    chk("rst_mem_req", 128'(bus.mem_req), 128'(0));
    chk("rst_mem_row", 128'(bus.mem_row), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single refill from requester 0.
    pend = 2'b01; f_row[0] = ROW_READ; f_addr[0] = 10'h2A7;
    serve(2, 1'b0, 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF);

    // Single write-back from requester 1, immediate ack.
    pend = 2'b10; f_row[1] = ROW_WRITE; f_addr[1] = 10'h15F; f_wdata[1] = {16{8'hA5}};
    serve(0, 1'b0, 1'b0, rnd128());

    // Continuous contention from reset.
    apply_reset();
    new_fields(0); new_fields(1);
    pend = 2'b11;
    for (int i = 0; i < 4; i++) serve(1, 1'b0, (i < 3), rnd128());
    serve(0, 1'b0, 1'b0, rnd128());

    // Latched fields ignore requester changes during ISSUE.
    pend = 2'b01; f_addr[0] = 10'h040; f_row[0] = ROW_READ;
    serve(3, 1'b1, 1'b0, rnd128());

    // Reset mid-ISSUE after a lone grant to 0 has moved the pointer to 1.
    pend = 2'b01; new_fields(0);
    drive_inputs();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.mem_req !== 1'b1 && cnt < 4);
    chk("pre_rst_mem_req", 128'(bus.mem_req), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 128'(bus.mem_req), 128'(0));
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    chk("midrst_done", 128'(bus.done), 128'(0));
    chk("midrst_rdata", bus.rdata, 128'(0));
    @(negedge clk);
    rst = 1'b0; m_ptr = 1'b0; m_rdata = '0;
    pend = 2'b11; new_fields(0); new_fields(1);
    serve(0, 1'b0, 1'b0, rnd128());
    serve(0, 1'b0, 1'b0, rnd128());

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          new_fields(i);
          pend[i] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        cnt = int'($urandom_range(0, 1));
        new_fields(cnt);
        pend[cnt] = 1'b1;
      end
      serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rnd128());
    end
    cnt = 0;
    while (pend != 2'b00 && cnt < 4) begin
      serve(0, 1'b0, 1'b0, rnd128());
      cnt++;
    end

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    pend = 2'b01; new_fields(0); f_row[0] = ROW_READ;
    drive_inputs();
    cnt = 0;
    while (bus.mem_req !== 1'b1 && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_len", 128'(cnt), 128'(15));
    chk("timeout_done", 128'(bus.done), 128'(2'b01));
    chk("timeout_err", 128'(bus.err), 128'(1));
    chk("timeout_rdata", bus.rdata, m_rdata);
    pend = 2'b00;
    drive_inputs();
    @(negedge clk);
    chk("timeout_done_once", 128'(bus.done), 128'(0));
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 128'(bus.err), 128'(1));
    rst = 1'b1;
    #1;
    chk("timeout_err_rst", 128'(bus.err), 128'(0));
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
